// File: rtl/instr_mem_prog.sv
// instr_mem_prog: runtime-loadable instruction memory for the accumulator core.
// After reset every word is cleared to NOP_OP (DEPTH cycles, busy=1). A streaming
// loader then writes programs from address 0. The fetch port answers one cycle
// after an accepted request. Addresses at or past the loaded length return END_OP.
//
// Ports:
//   clk, rst_n                     clock (rising edge), synchronous active-low reset
//   ld_start                       pulse: begin (or restart) a program load
//   ld_valid/ld_data/ld_last       loader beat, ld_last marks the final beat
//   ld_ready                       loader may transfer (high throughout a load)
//   ld_overflow                    sticky: beats dropped because memory was full
//   if_req/if_addr                 fetch request and address
//   if_valid/if_data               fetch response, one cycle after the request
//   busy                           clearing or loading, fetches not serviced
//   prog_len                       words in the current program (0..DEPTH)
//
// Optional feature macro INSTR_MEM_PARITY_EN adds a per-word even-parity bit,
// input par_inject (flips the stored parity on a load write) and output if_perr.
module instr_mem_prog #(
    parameter int unsigned          DATA_W = 8,
    parameter int unsigned          ADDR_W = 8,
    parameter int unsigned          DEPTH  = 256,
    parameter logic [DATA_W-1:0]    NOP_OP = '0,
    parameter logic [DATA_W-1:0]    END_OP = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                ld_overflow,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_data,
    output logic                busy,
`ifdef INSTR_MEM_PARITY_EN
    input  logic                par_inject,
    output logic                if_perr,
`endif
    output logic [ADDR_W:0]     prog_len
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PTR_W-1:0]   clr_ptr;
    logic               busy_d;
    logic               ld_ready_d;

    logic [DATA_W-1:0]  mem [DEPTH];
`ifdef INSTR_MEM_PARITY_EN
    logic               par_mem [DEPTH];
    logic               wpar;
    logic               rd_par;
`endif

    logic               we;
    logic [IDX_W-1:0]   widx;
    logic [DATA_W-1:0]  wdata;
    logic               xfer;
    logic               full;
    logic               fetch;
    logic               hit;
    logic [DATA_W-1:0]  rd_word;

    assign xfer    = ld_valid & ld_ready;
    // prog_len doubles as the load write pointer
    assign full    = (prog_len == PTR_W'(DEPTH));
    // ld_start wins over a simultaneous fetch request
    assign fetch   = (state == S_RUN) & if_req & ~ld_start;
    assign hit     = (PTR_W'(if_addr) < prog_len);
    assign rd_word = mem[IDX_W'(if_addr)];
`ifdef INSTR_MEM_PARITY_EN
    assign rd_par  = par_mem[IDX_W'(if_addr)];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_CLEAR: if (clr_ptr == PTR_W'(DEPTH - 1)) next_state = S_RUN;
            S_RUN:   if (ld_start) next_state = S_LOAD;
            S_LOAD:  if (!ld_start && xfer && ld_last) next_state = S_RUN;
            default: next_state = S_CLEAR;
        endcase
    end

    // Status outputs follow the state being entered so they are registered with it
    always_comb begin
        busy_d     = (next_state != S_RUN);
        ld_ready_d = (next_state == S_LOAD);
    end

    // Memory write port: clear sweep or loader beat (beats dropped once full)
    always_comb begin
        we    = 1'b0;
        widx  = '0;
        wdata = NOP_OP;
`ifdef INSTR_MEM_PARITY_EN
        wpar  = ^NOP_OP;
`endif
        case (state)
            S_CLEAR: begin
                we   = 1'b1;
                widx = IDX_W'(clr_ptr);
            end
            S_LOAD: begin
                we    = xfer & ~ld_start & ~full;
                widx  = IDX_W'(prog_len);
                wdata = ld_data;
`ifdef INSTR_MEM_PARITY_EN
                wpar  = (^ld_data) ^ par_inject;
`endif
            end
            default: ;
        endcase
    end

    // Storage array, no reset: contents are rebuilt by the clear sweep
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
`ifdef INSTR_MEM_PARITY_EN
            par_mem[widx] <= wpar;
`endif
        end
    end

    // Control datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_ptr     <= '0;
            prog_len    <= '0;
            ld_ready    <= 1'b0;
            ld_overflow <= 1'b0;
            if_valid    <= 1'b0;
            if_data     <= NOP_OP;
            busy        <= 1'b1;
`ifdef INSTR_MEM_PARITY_EN
            if_perr     <= 1'b0;
`endif
        end else begin
            busy     <= busy_d;
            ld_ready <= ld_ready_d;
            if_valid <= fetch;
            if (fetch) begin
                if_data <= hit ? rd_word : END_OP;
            end
`ifdef INSTR_MEM_PARITY_EN
            if_perr <= fetch & hit & ((^rd_word) != rd_par);
`endif
            case (state)
                S_CLEAR: clr_ptr <= clr_ptr + PTR_W'(1);
                S_RUN: begin
                    if (ld_start) begin
                        prog_len    <= '0;
                        ld_overflow <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_start) begin
                        prog_len    <= '0;
                        ld_overflow <= 1'b0;
                    end else if (xfer) begin
                        if (!full) begin
                            prog_len <= prog_len + PTR_W'(1);
                        end else begin
                            ld_overflow <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: two instances share all inputs, one with DEPTH=256 and
// one with DEPTH=4, compared against a program-level model of loads and fetches.
module tb_instr_mem_prog;

    logic        clk;
    logic        rst_n;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        par_inject;

    logic [1:0]       busy_o;
    logic [1:0]       ldr_o;
    logic [1:0]       ovf_o;
    logic [1:0]       ifv_o;
    logic [1:0]       perr_o;
    logic [1:0][7:0]  ifd_o;
    logic [1:0][8:0]  plen_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state per instance
    int         mdepth [2];
    logic [7:0] mmem   [2][256];
    int         mlen   [2];
    bit         movf   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_mem_prog #(.DEPTH(256)) u_big (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ldr_o[0]),
        .ld_overflow(ovf_o[0]), .if_req(if_req), .if_addr(if_addr),
        .if_valid(ifv_o[0]), .if_data(ifd_o[0]), .busy(busy_o[0]),
`ifdef INSTR_MEM_PARITY_EN
        .par_inject(par_inject), .if_perr(perr_o[0]),
`endif
        .prog_len(plen_o[0])
    );

    instr_mem_prog #(.DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ldr_o[1]),
        .ld_overflow(ovf_o[1]), .if_req(if_req), .if_addr(if_addr),
        .if_valid(ifv_o[1]), .if_data(ifd_o[1]), .busy(busy_o[1]),
`ifdef INSTR_MEM_PARITY_EN
        .par_inject(par_inject), .if_perr(perr_o[1]),
`endif
        .prog_len(plen_o[1])
    );

`ifndef INSTR_MEM_PARITY_EN
    assign perr_o = 2'b00;
`endif

    // ---------------- model ----------------
    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            mlen[k] = 0;
            movf[k] = 1'b0;
            for (int i = 0; i < 256; i++) mmem[k][i] = 8'h00;
        end
    endtask

    task automatic m_start();
        for (int k = 0; k < 2; k++) begin
            mlen[k] = 0;
            movf[k] = 1'b0;
        end
    endtask

    task automatic m_beat(input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            if (mlen[k] < mdepth[k]) begin
                mmem[k][mlen[k]] = d;
                mlen[k] = mlen[k] + 1;
            end else begin
                movf[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] m_fetch(input int k, input int a);
        return (a < mlen[k]) ? mmem[k][a] : 8'hFF;
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cyc();
        m_reset();
    endtask

    // Releases reset and counts cycles until each instance drops busy
    task automatic wait_clear(output int c0, output int c1);
        int c;
        c0 = -1;
        c1 = -1;
        c  = 0;
        rst_n = 1'b1;
        while ((c0 < 0 || c1 < 0) && c < 1000) begin
            cyc();
            c++;
            if (c0 < 0 && busy_o[0] === 1'b0) c0 = c;
            if (c1 < 0 && busy_o[1] === 1'b0) c1 = c;
        end
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
        m_start();
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input int gap);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        cyc();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        m_beat(d);
        repeat (gap) cyc();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int c0, c1;
        logic [7:0] e;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (busy_o[k] !== 1'b1) $display("FAIL reset_busy dut%0d got %b exp 1", k, busy_o[k]); else n_pass++;
            n_chk++; if (ldr_o[k] !== 1'b0) $display("FAIL reset_ld_ready dut%0d got %b exp 0", k, ldr_o[k]); else n_pass++;
            n_chk++; if (ovf_o[k] !== 1'b0) $display("FAIL reset_ovf dut%0d got %b exp 0", k, ovf_o[k]); else n_pass++;
            n_chk++; if (ifv_o[k] !== 1'b0) $display("FAIL reset_if_valid dut%0d got %b exp 0", k, ifv_o[k]); else n_pass++;
            n_chk++; if (ifd_o[k] !== 8'h00) $display("FAIL reset_if_data dut%0d got %h exp 00", k, ifd_o[k]); else n_pass++;
            n_chk++; if (plen_o[k] !== 9'd0) $display("FAIL reset_prog_len dut%0d got %0d exp 0", k, plen_o[k]); else n_pass++;
        end
        wait_clear(c0, c1);
        n_chk++; if (c0 != 256) $display("FAIL clear_cycles dut0 got %0d exp 256", c0); else n_pass++;
        n_chk++; if (c1 != 4) $display("FAIL clear_cycles dut1 got %0d exp 4", c1); else n_pass++;
        if_req  = 1'b1;
        if_addr = 8'd5;
        cyc();
        if_req  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = m_fetch(k, 5);
            n_chk++; if (ifv_o[k] !== 1'b1) $display("FAIL empty_fetch_valid dut%0d got %b exp 1", k, ifv_o[k]); else n_pass++;
            n_chk++; if (ifd_o[k] !== e) $display("FAIL empty_fetch_data dut%0d got %h exp %h", k, ifd_o[k], e); else n_pass++;
            n_chk++; if (plen_o[k] !== 9'd0) $display("FAIL empty_prog_len dut%0d got %0d exp 0", k, plen_o[k]); else n_pass++;
        end
    endtask

    task automatic test_load_gaps();
        logic [7:0] prog [4];
        logic [7:0] e;
        prog = '{8'hD5, 8'h51, 8'hD9, 8'hFF};
        start_load();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (ldr_o[k] !== 1'b1) $display("FAIL load_ld_ready dut%0d beat%0d got %b exp 1", k, i, ldr_o[k]); else n_pass++;
            end
            beat(prog[i], i == 3, (i == 3) ? 0 : 1);
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (busy_o[k] !== 1'b0) $display("FAIL load_busy_fall dut%0d got %b exp 0", k, busy_o[k]); else n_pass++;
            n_chk++; if (plen_o[k] !== 9'd4) $display("FAIL load_prog_len dut%0d got %0d exp 4", k, plen_o[k]); else n_pass++;
        end
        for (int a = 0; a < 5; a++) begin
            if_req  = 1'b1;
            if_addr = 8'(a);
            cyc();
            for (int k = 0; k < 2; k++) begin
                e = m_fetch(k, a);
                n_chk++; if (ifv_o[k] !== 1'b1 || ifd_o[k] !== e) $display("FAIL b2b_fetch dut%0d addr%0d got v=%b %h exp v=1 %h", k, a, ifv_o[k], ifd_o[k], e); else n_pass++;
            end
        end
        if_req = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ifv_o[k] !== 1'b0 || ifd_o[k] !== 8'hFF) $display("FAIL idle_hold dut%0d got v=%b %h exp v=0 ff", k, ifv_o[k], ifd_o[k]); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        start_load();
        for (int i = 0; i < 6; i++) begin
            n_chk++; if (ldr_o[1] !== 1'b1) $display("FAIL ovf_ld_ready dut1 beat%0d got %b exp 1", i, ldr_o[1]); else n_pass++;
            beat(8'h11 + 8'(i), i == 5, 0);
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (plen_o[k] !== 9'(mlen[k])) $display("FAIL ovf_prog_len dut%0d got %0d exp %0d", k, plen_o[k], mlen[k]); else n_pass++;
            n_chk++; if (ovf_o[k] !== movf[k]) $display("FAIL ovf_flag dut%0d got %b exp %b", k, ovf_o[k], movf[k]); else n_pass++;
            n_chk++; if (busy_o[k] !== 1'b0) $display("FAIL ovf_busy dut%0d got %b exp 0", k, busy_o[k]); else n_pass++;
        end
        for (int a = 3; a < 5; a++) begin
            if_req  = 1'b1;
            if_addr = 8'(a);
            cyc();
            for (int k = 0; k < 2; k++) begin
                e = m_fetch(k, a);
                n_chk++; if (ifv_o[k] !== 1'b1 || ifd_o[k] !== e) $display("FAIL ovf_fetch dut%0d addr%0d got v=%b %h exp v=1 %h", k, a, ifv_o[k], ifd_o[k], e); else n_pass++;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_restart();
        logic [7:0] e;
        start_load();
        beat(8'h01, 1'b0, 0);
        beat(8'h02, 1'b0, 0);
        // restart with a beat in the same cycle; the beat must be discarded
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h03;
        cyc();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        m_start();
        beat(8'hAA, 1'b0, 0);
        beat(8'hBB, 1'b1, 0);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (plen_o[k] !== 9'd2) $display("FAIL restart_prog_len dut%0d got %0d exp 2", k, plen_o[k]); else n_pass++;
            n_chk++; if (ovf_o[k] !== 1'b0) $display("FAIL restart_ovf dut%0d got %b exp 0", k, ovf_o[k]); else n_pass++;
        end
        for (int a = 0; a < 3; a += 2) begin
            if_req  = 1'b1;
            if_addr = 8'(a);
            cyc();
            for (int k = 0; k < 2; k++) begin
                e = m_fetch(k, a);
                n_chk++; if (ifv_o[k] !== 1'b1 || ifd_o[k] !== e) $display("FAIL restart_fetch dut%0d addr%0d got v=%b %h exp v=1 %h", k, a, ifv_o[k], ifd_o[k], e); else n_pass++;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset_midload();
        int c0, c1;
        start_load();
        beat(8'h55, 1'b0, 0);
        apply_reset();
        wait_clear(c0, c1);
        n_chk++; if (c0 != 256) $display("FAIL reclear_cycles dut0 got %0d exp 256", c0); else n_pass++;
        n_chk++; if (c1 != 4) $display("FAIL reclear_cycles dut1 got %0d exp 4", c1); else n_pass++;
        if_req  = 1'b1;
        if_addr = 8'd0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (plen_o[k] !== 9'd0) $display("FAIL reclear_prog_len dut%0d got %0d exp 0", k, plen_o[k]); else n_pass++;
            n_chk++; if (ifv_o[k] !== 1'b1 || ifd_o[k] !== 8'hFF) $display("FAIL reclear_fetch dut%0d got v=%b %h exp v=1 ff", k, ifv_o[k], ifd_o[k]); else n_pass++;
        end
        // simultaneous ld_start and if_req: load wins, fetch dropped
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
        if_req   = 1'b0;
        m_start();
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ifv_o[k] !== 1'b0 || busy_o[k] !== 1'b1) $display("FAIL start_vs_fetch dut%0d got v=%b busy=%b exp v=0 busy=1", k, ifv_o[k], busy_o[k]); else n_pass++;
        end
        beat(8'h77, 1'b1, 0);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (plen_o[k] !== 9'd1) $display("FAIL after_start_len dut%0d got %0d exp 1", k, plen_o[k]); else n_pass++;
        end
    endtask

    task automatic test_random();
        int len;
        int a;
        logic [7:0] e;
        logic [7:0] last_d [2];
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(1, 8);
            start_load();
            for (int i = 0; i < len; i++) beat(8'($urandom), i == len - 1, $urandom_range(0, 2));
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (plen_o[k] !== 9'(mlen[k]) || ovf_o[k] !== movf[k]) $display("FAIL rand_len dut%0d got %0d/%b exp %0d/%b", k, plen_o[k], ovf_o[k], mlen[k], movf[k]); else n_pass++;
            end
            for (int f = 0; f < 12; f++) begin
                a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, len + 2);
                if_req  = ($urandom_range(0, 4) != 0);
                if_addr = 8'(a);
                cyc();
                for (int k = 0; k < 2; k++) begin
                    if (if_req) begin
                        e = m_fetch(k, a);
                        last_d[k] = e;
                        n_chk++; if (ifv_o[k] !== 1'b1 || ifd_o[k] !== e || perr_o[k] !== 1'b0) $display("FAIL rand_fetch dut%0d addr%0d got v=%b %h p=%b exp v=1 %h p=0", k, a, ifv_o[k], ifd_o[k], perr_o[k], e); else n_pass++;
                    end else if (f > 0) begin
                        n_chk++; if (ifv_o[k] !== 1'b0 || ifd_o[k] !== last_d[k]) $display("FAIL rand_idle dut%0d got v=%b %h exp v=0 %h", k, ifv_o[k], ifd_o[k], last_d[k]); else n_pass++;
                    end
                end
            end
            if_req = 1'b0;
            cyc();
        end
    endtask

`ifdef INSTR_MEM_PARITY_EN
    task automatic test_parity();
        start_load();
        par_inject = 1'b0;
        beat(8'h3C, 1'b0, 0);
        par_inject = 1'b1;
        beat(8'h3D, 1'b1, 0);
        par_inject = 1'b0;
        for (int a = 0; a < 3; a++) begin
            if_req  = 1'b1;
            if_addr = 8'(a);
            cyc();
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (ifd_o[k] !== m_fetch(k, a) || perr_o[k] !== (a == 1)) $display("FAIL parity dut%0d addr%0d got %h p=%b exp %h p=%b", k, a, ifd_o[k], perr_o[k], m_fetch(k, a), (a == 1)); else n_pass++;
            end
        end
        if_req = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        mdepth[0]  = 256;
        mdepth[1]  = 4;
        rst_n      = 1'b0;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 8'h00;
        ld_last    = 1'b0;
        if_req     = 1'b0;
        if_addr    = 8'h00;
        par_inject = 1'b0;
        m_reset();
        test_reset();
        test_load_gaps();
        test_overflow();
        test_restart();
        test_reset_midload();
        test_random();
`ifdef INSTR_MEM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
